// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame defaults and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;
    localparam int OVERSAMPLE      = 16;
    localparam int MID_START       = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous line inputs; resets to 1 (idle line level).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver. Define UART_RX_PARITY_EN to add an even-parity bit
// between the data and stop bits; otherwise frames are plain 8N1 and parity_err is 0.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s to fall
// START  | counting to the middle of the start bit to confirm it
// DATA   | sampling DBIT data bits at mid-bit, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting out the stop bit(s), then publishing the frame
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int SW = $clog2(SB_TICK);

    uart_state_t     state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [2:0]      n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next;
    logic            frame_err_next;
    logic            rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_pend, par_pend_next;
    logic parity_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_pend   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_pend   <= par_pend_next;
            parity_err <= parity_err_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        s_next         = s;
        n_next         = n;
        b_next         = b;
        dout_next      = dout;
        done_next      = 1'b0;
        frame_err_next = frame_err;
`ifdef UART_RX_PARITY_EN
        par_pend_next   = par_pend;
        parity_err_next = parity_err;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(MID_START)) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(OVERSAMPLE - 1)) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 3'd1;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == SW'(OVERSAMPLE - 1)) begin
                        s_next        = '0;
                        par_pend_next = (^b) ^ rx_s;
                        state_next    = STOP;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        dout_next      = b;
                        frame_err_next = ~rx_s;
                        done_next      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_next = par_pend;
`endif
                        state_next     = IDLE;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: s_tick every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx_oversample;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       parity_err;

    int         n_total = 0;
    int         n_pass  = 0;
    int         done_cnt = 0;
    int         base;
    logic [7:0] cap_dout [64];
    logic       cap_fe   [64];
    logic       cap_pe   [64];

    uart_rx_oversample #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            if (done_cnt < 64) begin
                cap_dout[done_cnt] = dout;
                cap_fe[done_cnt]   = frame_err;
                cap_pe[done_cnt]   = parity_err;
            end
            done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic wait_clk(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input int stop_len);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_clk(BIT_CLK);
`else
        if (par_bit) rx = 1'b1;
`endif
        rx = stop_bit;
        wait_clk(stop_len);
        rx = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(3);
        chk("reset_done", {31'd0, rx_done_tick}, 0);
        chk("reset_dout", {24'd0, dout}, 0);
        chk("reset_fe", {31'd0, frame_err}, 0);
        chk("reset_pe", {31'd0, parity_err}, 0);
        reset = 1'b0;
        wait_clk(BIT_CLK);

        // clean frame
        send_frame(8'hA5, 1'b1, 1'b0, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("a5_count", done_cnt, 1);
        chk("a5_dout", {24'd0, cap_dout[0]}, 32'hA5);
        chk("a5_fe", {31'd0, cap_fe[0]}, 0);
        chk("a5_pe", {31'd0, cap_pe[0]}, 0);

        // start glitch of 5 ticks
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        chk("glitch_count", done_cnt, 1);
        chk("glitch_dout", {24'd0, dout}, 32'hA5);

        // bad stop bit: low long enough to cover the mid-bit stop sample only
        send_frame(8'h3C, 1'b0, 1'b0, 44);
        wait_clk(3 * BIT_CLK);
        chk("3c_count", done_cnt, 2);
        chk("3c_dout", {24'd0, cap_dout[1]}, 32'h3C);
        chk("3c_fe", {31'd0, cap_fe[1]}, 1);
        chk("3c_fe_held", {31'd0, frame_err}, 1);

        send_frame(8'h00, 1'b1, 1'b0, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("00_count", done_cnt, 3);
        chk("00_dout", {24'd0, cap_dout[2]}, 32'h00);
        chk("00_fe", {31'd0, cap_fe[2]}, 0);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 1'b0, BIT_CLK);
        send_frame(8'hFF, 1'b1, 1'b0, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("b2b_count", done_cnt, 5);
        chk("b2b_first", {24'd0, cap_dout[3]}, 32'h00);
        chk("b2b_second", {24'd0, cap_dout[4]}, 32'hFF);
        chk("b2b_dout_held", {24'd0, dout}, 32'hFF);

        // reset after data bit 3 of 0xFF
        rx = 1'b0;
        wait_clk(BIT_CLK);
        rx = 1'b1;
        wait_clk(4 * BIT_CLK);
        reset = 1'b1;
        wait_clk(2);
        chk("rst_mid_dout", {24'd0, dout}, 0);
        chk("rst_mid_done", {31'd0, rx_done_tick}, 0);
        chk("rst_mid_fe", {31'd0, frame_err}, 0);
        reset = 1'b0;
        wait_clk(7 * BIT_CLK);
        chk("rst_mid_count", done_cnt, 5);
        chk("rst_mid_dout_after", {24'd0, dout}, 0);

        send_frame(8'h81, 1'b1, 1'b0, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("81_count", done_cnt, 6);
        chk("81_dout", {24'd0, cap_dout[5]}, 32'h81);
        chk("81_fe", {31'd0, cap_fe[5]}, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("par_ok_count", done_cnt, 7);
        chk("par_ok_dout", {24'd0, cap_dout[6]}, 32'h07);
        chk("par_ok_pe", {31'd0, cap_pe[6]}, 0);
        send_frame(8'h07, 1'b1, 1'b0, BIT_CLK);
        wait_clk(2 * BIT_CLK);
        chk("par_bad_count", done_cnt, 8);
        chk("par_bad_pe", {31'd0, cap_pe[7]}, 1);
        chk("par_bad_pe_held", {31'd0, parity_err}, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receiver that consumes the baud-rate tick from the mod-M counter stage directly upstream.
- Samples the serial line at 16x oversampling and deserialises one frame: start bit, DBIT data bits LSB first, stop bit(s).
- Presents the received byte with a one-cycle done pulse to the downstream FIFO or interface logic.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, oversampling ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  oversampling enable pulse from the mod-M counter; one clk wide, 16 per bit period.
- rx  input  1  asynchronous serial line, idle high.
- rx_done_tick  output  1  one-cycle pulse when a frame completes.
- dout  output  DBIT  received data, LSB = first bit on the wire.
- frame_err  output  1  high if the sampled stop bit was 0; valid with rx_done_tick and held until the next done pulse.
- parity_err  output  1  parity mismatch flag; see Optional Feature.

Behaviour:
- Reset:
  - state = IDLE; s, n, data shift register and dout = 0.
  - rx_done_tick, frame_err, parity_err = 0.
  - Synchroniser flops = 1 (line idle).
- rx passes through a 2-flop synchroniser. All decisions use the synchronised signal rx_s, which lags rx by 2 clk.
- Counters:
  - s: 4-bit tick counter. Advances only on cycles where s_tick = 1.
  - n: 3-bit bit counter.
- FSM (all transitions on clk edges):
  - IDLE: when rx_s = 0, go to START with s = 0. s_tick is not required to detect the falling edge.
  - START: on each s_tick, s++. On the tick where s == 7 (mid start bit):
    - if rx_s = 0: go to DATA, s = 0, n = 0;
    - else (glitch): return to IDLE with no done pulse.
  - DATA: on each s_tick, s++. On the tick where s == 15:
    - s wraps to 0;
    - shift register b = {rx_s, b[DBIT-1:1]};
    - if n == DBIT-1, go to STOP (or PARITY when enabled); else n++.
  - STOP: on each s_tick, s++. On the tick where s == SB_TICK-1:
    - dout <= b; frame_err <= ~rx_s; rx_done_tick <= 1 on the next cycle only;
    - return to IDLE.
- Latency: rx_done_tick rises 1 clk after the final stop-sample tick.
- dout and frame_err hold their values until the next completed frame.
- s_tick arriving while in IDLE is ignored.
- A new falling edge during STOP is not detected until IDLE is re-entered. Back-to-back frames must still be received, because the stop sample is mid-bit.
- Reset asserted mid-frame aborts the frame immediately: no done pulse, and all outputs return to reset values.
- Data bit order: LSB first. After DBIT shifts, b[0] is the first data bit received.
- s counter width is 5 bits when SB_TICK > 16. Width = $clog2(SB_TICK).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP. It lasts 16 ticks and samples on s == 15.
  - Even parity is checked: parity_err <= (^b) ^ rx_s, updated together with dout.
- Undefined:
  - PARITY state absent and parity_err tied to 0.
  - Frame format is 8N1.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants IDLE / START / DATA / PARITY / STOP (3-bit);
  - default DBIT and SB_TICK values;
  - OVERSAMPLE = 16 and MID_START = 7.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1. It is reused by other line inputs.

Test Plan:
- Drive s_tick every 4 clk and send frame 0xA5 with a valid stop bit -> exactly one rx_done_tick, dout = 0xA5, frame_err = 0.
- rx low for 5 ticks, then high (glitch) -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
- Send 0x3C with stop bit = 0 -> rx_done_tick pulses, dout = 0x3C, frame_err = 1. A following valid frame 0x00 clears frame_err to 0.
- Assert reset for 2 clk after data bit 3 of 0xFF -> all outputs 0, no done pulse. Next frame 0x81 is received correctly.
- Send back-to-back frames 0x00 then 0xFF with no idle gap -> two done pulses, dout = 0x00 then 0xFF.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 1 -> parity_err = 0. Same data with parity bit 0 -> parity_err = 1.
